// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
//   Shared constants and types for the USB transmit bit-level path.
//
//   USB_RUN_LEN_DEFAULT : number of consecutive raw 1s that forces a stuffed 0
//   USB_J_LEVEL         : idle (J) line level
//   USB_K_LEVEL         : opposite (K) line level
//   usb_emit_t          : one emission slot as seen by the line side
// -----------------------------------------------------------------------------
package usb_pkg;

  localparam int   USB_RUN_LEN_DEFAULT = 6;
  localparam logic USB_J_LEVEL         = 1'b1;
  localparam logic USB_K_LEVEL         = 1'b0;

  // One emitted bit: raw (pre-NRZI) value, whether it was inserted by the
  // stuffer, and whether the slot carries a bit at all.
  typedef struct packed {
    logic valid;
    logic stuffed;
    logic raw;
  } usb_emit_t;

  // NRZI rule: a raw 0 produces a line transition, a raw 1 holds the line.
  function automatic logic usb_nrzi_toggles(input logic raw);
    return ~raw;
  endfunction

endpackage

// File: rtl/usb_nrzi_enc.sv
// -----------------------------------------------------------------------------
// usb_nrzi_enc
//   Holds the NRZI line register. The line flips whenever en_toggle is set
//   and returns to the idle level on reset or on a packet-boundary clear.
//
//   clk        in  system clock
//   nRST       in  asynchronous reset, active low
//   en_toggle  in  flip the line on this clock edge
//   clr        in  synchronous return to IDLE_LEVEL (wins over en_toggle)
//   line       out current line level
// -----------------------------------------------------------------------------
module usb_nrzi_enc
  import usb_pkg::*;
#(
  parameter logic IDLE_LEVEL = USB_J_LEVEL
) (
  input  logic clk,
  input  logic nRST,
  input  logic en_toggle,
  input  logic clr,
  output logic line
);

  logic line_q;
  logic line_d;

  always_comb begin
    line_d = line_q;
    if (clr) begin
      line_d = IDLE_LEVEL;
    end else if (en_toggle) begin
      line_d = ~line_q;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      line_q <= IDLE_LEVEL;
    end else begin
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/usb_bit_stuff_nrzi_tx.sv
// -----------------------------------------------------------------------------
// usb_bit_stuff_nrzi_tx
//   Transmit-side USB bit stuffer with integrated NRZI encoder. After RUN_LEN
//   consecutive counted raw 1s a 0 is inserted; the source is stalled (in_ready
//   low) for that slot. Bypass bits are passed through without being counted.
//   One bit time advances per en tick; emissions appear one clk after en.
//
//   clk          in   system clock
//   nRST         in   asynchronous reset, active low
//   en           in   bit-time strobe, one clk wide
//   clr          in   synchronous packet-boundary clear (beats en)
//   in_bit       in   raw data bit
//   in_valid     in   in_bit is valid
//   in_bypass    in   in_bit is neither counted nor stuffed
//   in_ready     out  bit is consumed this clk when in_valid & en
//   out_bit      out  NRZI-encoded line bit
//   out_raw      out  pre-NRZI bit, stuffed bits included
//   out_valid    out  one-clk pulse, out_bit/out_raw updated
//   out_stuffed  out  qualifies out_valid: bit was inserted
//   stuff_total  out  saturating count of inserted bits since reset
// -----------------------------------------------------------------------------
module usb_bit_stuff_nrzi_tx
  import usb_pkg::*;
#(
  parameter int   RUN_LEN    = USB_RUN_LEN_DEFAULT,
  parameter logic IDLE_LEVEL = USB_J_LEVEL,
  parameter int   STAT_W     = 16
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              en,
  input  logic              clr,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              in_bypass,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_raw,
  output logic              out_valid,
  output logic              out_stuffed,
  output logic [STAT_W-1:0] stuff_total
);

  localparam int                RUN_W   = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(RUN_LEN);

  generate
    if (RUN_LEN < 1) begin : g_bad_run_len
      $error("usb_bit_stuff_nrzi_tx: RUN_LEN must be at least 1");
    end
  endgenerate

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [RUN_W-1:0]  run_q;
  logic [RUN_W-1:0]  run_d;
  usb_emit_t         emit_q;
  usb_emit_t         emit_d;
  logic [STAT_W-1:0] stat_q;
  logic [STAT_W-1:0] stat_d;
  logic              stuff_pend;
  logic              line;

  // A full run means the next bit slot belongs to the stuffed 0.
  assign stuff_pend = (run_q == RUN_MAX);

  // nRST gating keeps the source stalled while the block is held in reset.
  assign in_ready = nRST & en & ~clr & ~stuff_pend;

  always_comb begin
    run_d          = run_q;
    stat_d         = stat_q;
    emit_d.valid   = 1'b0;
    emit_d.stuffed = 1'b0;
    emit_d.raw     = emit_q.raw;
    if (clr) begin
      // Dropping the run also drops any pending stuff.
      run_d = '0;
    end else if (en) begin
      if (stuff_pend) begin
        emit_d.valid   = 1'b1;
        emit_d.stuffed = 1'b1;
        emit_d.raw     = 1'b0;
        run_d          = '0;
        stat_d         = sat_inc(stat_q);
      end else if (in_valid) begin
        emit_d.valid = 1'b1;
        emit_d.raw   = in_bit;
        if (in_bypass || !in_bit) begin
          run_d = '0;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      run_q          <= '0;
      stat_q         <= '0;
      emit_q.valid   <= 1'b0;
      emit_q.stuffed <= 1'b0;
      emit_q.raw     <= 1'b1;
    end else begin
      run_q  <= run_d;
      stat_q <= stat_d;
      emit_q <= emit_d;
    end
  end

  usb_nrzi_enc #(
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_nrzi (
    .clk       (clk),
    .nRST      (nRST),
    .en_toggle (emit_d.valid & usb_nrzi_toggles(emit_d.raw)),
    .clr       (clr),
    .line      (line)
  );

  assign out_bit     = line;
  assign out_raw     = emit_q.raw;
  assign out_valid   = emit_q.valid;
  assign out_stuffed = emit_q.stuffed;
  assign stuff_total = stat_q;

endmodule

// File: tb/tb_usb_bit_stuff_nrzi_tx.sv
module tb_usb_bit_stuff_nrzi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nRST, en, clr;
  logic a_bit, a_valid, a_byp, a_ready, a_obit, a_oraw, a_ovld, a_ostf;
  logic b_bit, b_valid, b_byp, b_ready, b_obit, b_oraw, b_ovld, b_ostf;
  logic [15:0] a_tot, b_tot;

  usb_bit_stuff_nrzi_tx #(.RUN_LEN(6), .IDLE_LEVEL(1'b1), .STAT_W(16)) u_dut_a (
    .clk(clk), .nRST(nRST), .en(en), .clr(clr),
    .in_bit(a_bit), .in_valid(a_valid), .in_bypass(a_byp), .in_ready(a_ready),
    .out_bit(a_obit), .out_raw(a_oraw), .out_valid(a_ovld), .out_stuffed(a_ostf),
    .stuff_total(a_tot)
  );

  usb_bit_stuff_nrzi_tx #(.RUN_LEN(3), .IDLE_LEVEL(1'b1), .STAT_W(16)) u_dut_b (
    .clk(clk), .nRST(nRST), .en(en), .clr(clr),
    .in_bit(b_bit), .in_valid(b_valid), .in_bypass(b_byp), .in_ready(b_ready),
    .out_bit(b_obit), .out_raw(b_oraw), .out_valid(b_ovld), .out_stuffed(b_ostf),
    .stuff_total(b_tot)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic raw;
    logic stuffed;
    logic line;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Reference model state per DUT (0: RUN_LEN=6, 1: RUN_LEN=3)
  int   run_m[2];
  logic line_m[2];
  int   tot_m[2];
  logic took_a, took_b;

  // Emission logs (newest bit in LSB) and counts
  logic [63:0] raw_log_a = '0, stf_log_a = '0, raw_log_b = '0;
  int n_emit_a = 0, n_emit_b = 0;
  exp_t e_a, e_b;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      run_m[k]  = 0;
      line_m[k] = 1'b1;
      tot_m[k]  = 0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic model_step(input int k, input logic v, input logic b, input logic byp,
                            output logic rdy, output logic took);
    int   rl;
    exp_t e;
    rl   = (k == 0) ? 6 : 3;
    rdy  = 1'b0;
    took = 1'b0;
    if (clr) begin
      run_m[k]  = 0;
      line_m[k] = 1'b1;
    end else if (run_m[k] == rl) begin
      run_m[k]  = 0;
      tot_m[k]++;
      line_m[k] = ~line_m[k];
      e = '{raw: 1'b0, stuffed: 1'b1, line: line_m[k]};
      if (k == 0) qa.push_back(e); else qb.push_back(e);
    end else begin
      rdy = 1'b1;
      if (v) begin
        took = 1'b1;
        if (!b) line_m[k] = ~line_m[k];
        run_m[k] = (byp || !b) ? 0 : run_m[k] + 1;
        e = '{raw: b, stuffed: 1'b0, line: line_m[k]};
        if (k == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
  endtask

  // One en tick on the current inputs; en then stays low for one clk.
  task automatic tick();
    logic ra, ta, rb, tb2;
    @(posedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    model_step(0, a_valid, a_bit, a_byp, ra, ta);
    model_step(1, b_valid, b_bit, b_byp, rb, tb2);
    check("a_in_ready", 32'(a_ready), 32'(ra));
    check("b_in_ready", 32'(b_ready), 32'(rb));
    took_a = ta;
    took_b = tb2;
    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic send(input int k, input logic b, input logic byp);
    logic done;
    done = 1'b0;
    if (k == 0) begin a_valid = 1'b1; a_bit = b; a_byp = byp; end
    else        begin b_valid = 1'b1; b_bit = b; b_byp = byp; end
    for (int i = 0; i < 4 && !done; i++) begin
      tick();
      done = (k == 0) ? took_a : took_b;
    end
    if (!done) check("send_timeout", 32'(done), 32'd1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_byp   = 1'b0;
    b_byp   = 1'b0;
  endtask

  task automatic send_n(input int k, input int n, input logic b, input logic byp);
    for (int i = 0; i < n; i++) send(k, b, byp);
  endtask

  task automatic clr_tick();
    clr = 1'b1;
    tick();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard: pop one expectation per observed emission.
  always @(negedge clk) begin
    if (a_ovld) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e_a = qa.pop_front();
        check("a_out_raw", 32'(a_oraw), 32'(e_a.raw));
        check("a_out_stuffed", 32'(a_ostf), 32'(e_a.stuffed));
        check("a_out_bit", 32'(a_obit), 32'(e_a.line));
      end
      raw_log_a = {raw_log_a[62:0], a_oraw};
      stf_log_a = {stf_log_a[62:0], a_ostf};
      n_emit_a++;
    end
    if (b_ovld) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e_b = qb.pop_front();
        check("b_out_raw", 32'(b_oraw), 32'(e_b.raw));
        check("b_out_stuffed", 32'(b_ostf), 32'(e_b.stuffed));
        check("b_out_bit", 32'(b_obit), 32'(e_b.line));
      end
      raw_log_b = {raw_log_b[62:0], b_oraw};
      n_emit_b++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    nRST = 1'b0; en = 1'b1; clr = 1'b0;
    a_bit = 1'b0; a_valid = 1'b0; a_byp = 1'b0;
    b_bit = 1'b0; b_valid = 1'b0; b_byp = 1'b0;
    model_reset();
    #12;
    // Reset state
    check("rst_in_ready", 32'(a_ready), 32'd0);
    check("rst_out_bit", 32'(a_obit), 32'd1);
    check("rst_out_raw", 32'(a_oraw), 32'd1);
    check("rst_out_valid", 32'(a_ovld), 32'd0);
    check("rst_out_stuffed", 32'(a_ostf), 32'd0);
    check("rst_stuff_total", 32'(a_tot), 32'd0);
    en = 1'b0;
    @(negedge clk);
    nRST = 1'b1;

    // 1) ten 1s, a 0, ten 1s
    n0 = n_emit_a;
    send_n(0, 10, 1'b1, 1'b0);
    send(0, 1'b0, 1'b0);
    send_n(0, 10, 1'b1, 1'b0);
    settle();
    check("t1_emit_count", 32'(n_emit_a - n0), 32'd23);
    check("t1_raw_seq", 32'(raw_log_a[22:0]), 32'(23'b11111101111011111101111));
    check("t1_stuff_pos", 32'(stf_log_a[22:0]), 32'(23'b00000010000000000010000));
    check("t1_stuff_total", 32'(a_tot), 32'd2);
    clr_tick();
    settle();

    // 2) exactly six 1s, then 0: stuff lands before the data 0
    n0 = n_emit_a;
    send_n(0, 6, 1'b1, 1'b0);
    send(0, 1'b0, 1'b0);
    settle();
    check("t2_emit_count", 32'(n_emit_a - n0), 32'd8);
    check("t2_raw_seq", 32'(raw_log_a[7:0]), 32'(8'b11111100));
    check("t2_line_end", 32'(a_obit), 32'd1);
    check("t2_stuff_total", 32'(a_tot), 32'd3);
    clr_tick();
    settle();

    // 3) RUN_LEN=3, seven 1s
    n0 = n_emit_b;
    send_n(1, 7, 1'b1, 1'b0);
    settle();
    check("t3_emit_count", 32'(n_emit_b - n0), 32'd9);
    check("t3_raw_seq", 32'(raw_log_b[8:0]), 32'(9'b111011101));
    check("t3_stuff_total", 32'(b_tot), 32'd2);
    clr_tick();
    settle();

    // 4) 0 then five 1s (line low), clr, five more 1s: no stuff
    send(0, 1'b0, 1'b0);
    send_n(0, 5, 1'b1, 1'b0);
    settle();
    check("t4_line_before_clr", 32'(a_obit), 32'd0);
    clr_tick();
    settle();
    check("t4_line_after_clr", 32'(a_obit), 32'd1);
    check("t4_valid_after_clr", 32'(a_ovld), 32'd0);
    send_n(0, 5, 1'b1, 1'b0);
    settle();
    check("t4_stuff_total", 32'(a_tot), 32'd3);

    // 5) six bypass 1s, then five counted 1s: run stays at 0 through bypass
    clr_tick();
    send_n(0, 6, 1'b1, 1'b1);
    send_n(0, 5, 1'b1, 1'b0);
    settle();
    check("t5_stuff_total", 32'(a_tot), 32'd3);
    check("t5_line_held", 32'(a_obit), 32'd1);
    clr_tick();
    settle();

    // Random traffic on the RUN_LEN=6 unit, scoreboard-checked
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 5) == 0) tick();
      else send(0, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 9) == 0));
    end
    settle();
    check("rand_stuff_total", 32'(a_tot), 32'(tot_m[0]));
    check("rand_queue_empty", 32'(qa.size()), 32'd0);
    clr_tick();
    settle();

    // 6) line low, stuff pending, then async reset mid-clk
    send(0, 1'b0, 1'b0);
    send_n(0, 6, 1'b1, 1'b0);
    settle();
    #2;
    nRST = 1'b0;
    en   = 1'b1;
    #1;
    check("t6_out_bit", 32'(a_obit), 32'd1);
    check("t6_out_raw", 32'(a_oraw), 32'd1);
    check("t6_out_valid", 32'(a_ovld), 32'd0);
    check("t6_out_stuffed", 32'(a_ostf), 32'd0);
    check("t6_stuff_total", 32'(a_tot), 32'd0);
    check("t6_in_ready", 32'(a_ready), 32'd0);
    model_reset();
    en = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    n0 = n_emit_a;
    repeat (3) tick();
    settle();
    check("t6_no_stuff_after", 32'(n_emit_a - n0), 32'd0);
    check("t6_total_after", 32'(a_tot), 32'd0);

    check("final_queue_a", 32'(qa.size()), 32'd0);
    check("final_queue_b", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
